// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Decode/issue stage of the 5-stage pipeline, between register-file read and
// execute. Forms the ALU operands (with a sign- or zero-extended immediate
// for I-type instructions), holds them in the D/X pipeline register, and
// inserts a single bubble on a load-use hazard. A saturating counter records
// how many hazard bubbles were inserted.
//
// Ports
//   clock, reset           rising-edge clock, synchronous active-high reset
//   in_valid, in_nop       upstream instruction present / is a nop
//   pc, target             instruction PC and jump target
//   opcode, rd, rs, rt,
//   shamt, aluop           instruction fields
//   imm                    raw immediate (IMM_W bits)
//   en, mwen, lw           regfile write enable, memory write enable, load
//   data_readRegA/B        regfile read data for rs / rt
//   flush                  squash the stage (taken branch / jump)
//   ex_ready               execute accepts the D/X contents this cycle
//   stall                  combinational; upstream must hold its inputs
//   out_*                  registered D/X contents
//   num_a, num_b           registered ALU operands
//   out_regB               registered raw rt data (store data, branch compare)
//   stall_count            saturating count of hazard bubbles
//
// Handshake: the D/X register holds a valid instruction until a cycle in
// which ex_ready is high; a bubble (out_valid=0) is always replaceable, so
// ex_ready is ignored while out_valid is low. Upstream holds pc/fields/data
// steady in any cycle where stall is high and re-presents them next cycle.
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned PC_W     = 12,
  parameter int unsigned IMM_W    = 17,
  parameter bit          SIGN_EXT = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_nop,
  input  logic [PC_W-1:0]   pc,
  input  logic [4:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        shamt,
  input  logic [4:0]        aluop,
  input  logic [IMM_W-1:0]  imm,
  input  logic [PC_W-1:0]   target,
  input  logic              en,
  input  logic              mwen,
  input  logic              lw,
  input  logic [DATA_W-1:0] data_readRegA,
  input  logic [DATA_W-1:0] data_readRegB,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              stall,
  output logic              out_valid,
  output logic              out_nop,
  output logic [PC_W-1:0]   out_pc,
  output logic [PC_W-1:0]   out_target,
  output logic [4:0]        out_opcode,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_shamt,
  output logic [4:0]        out_aluop,
  output logic [DATA_W-1:0] num_a,
  output logic [DATA_W-1:0] num_b,
  output logic [DATA_W-1:0] out_regB,
  output logic              out_en,
  output logic              out_mwen,
  output logic              out_lw,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [4:0] OP_SW  = 5'b00111;
  localparam logic [4:0] OP_AI  = 5'b00101;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_BLT = 5'b00110;

  // Contents of the D/X pipeline register.
  typedef struct packed {
    logic              valid;
    logic              nop;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   target;
    logic [4:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [4:0]        aluop;
    logic [DATA_W-1:0] num_a;
    logic [DATA_W-1:0] num_b;
    logic [DATA_W-1:0] regb;
    logic              en;
    logic              mwen;
    logic              lw;
  } dx_t;

  dx_t              r_dx;
  logic [CNT_W-1:0] r_stall_count;

  dx_t              w_dx_next;
  dx_t              w_dx_load;
  dx_t              w_dx_bubble;
  logic [DATA_W-1:0] w_ext;
  logic             w_i_type;
  logic             w_uses_rt;
  logic             w_hazard;
  logic             w_hold;
  logic             w_live;

  // -------------------------------------------------------------------------
  // Immediate extension
  // -------------------------------------------------------------------------
  if (IMM_W < DATA_W) begin : g_ext_wide
    if (SIGN_EXT) begin : g_sign
      assign w_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    end else begin : g_zero
      assign w_ext = {{(DATA_W-IMM_W){1'b0}}, imm};
    end
  end else begin : g_ext_full
    assign w_ext = imm;
  end

  // -------------------------------------------------------------------------
  // Decode and hazard detection
  // -------------------------------------------------------------------------
  assign w_i_type  = (opcode == OP_SW) | (opcode == OP_AI) |
                     (opcode == OP_BNE) | (opcode == OP_BLT) | lw;
  // addi and lw write rt-less forms; their rt field is not a source register.
  assign w_uses_rt = ~((opcode == OP_AI) | lw);

  // A load in D/X whose destination is read by the incoming instruction.
  // rd=0 is the hardwired zero register and never creates a dependence.
  assign w_hazard = in_valid & ~in_nop & r_dx.valid & r_dx.lw &
                    (r_dx.rd != 5'd0) &
                    ((rs == r_dx.rd) | (w_uses_rt & (rt == r_dx.rd)));

  // Only a valid instruction can be blocked by execute.
  assign w_hold = r_dx.valid & ~ex_ready;

  // Reset and flush both discard the upstream instruction, so nothing
  // needs to be held in those cycles.
  assign stall = ~reset & ~flush & (w_hazard | w_hold);

  assign w_live = in_valid & ~in_nop;

  always_comb begin
    w_dx_bubble     = '0;
    w_dx_bubble.nop = 1'b1;
  end

  always_comb begin
    w_dx_load        = '0;
    w_dx_load.valid  = in_valid;
    w_dx_load.nop    = in_nop;
    w_dx_load.pc     = pc;
    w_dx_load.target = target;
    w_dx_load.opcode = opcode;
    w_dx_load.rd     = rd;
    w_dx_load.shamt  = shamt;
    w_dx_load.aluop  = aluop;
    w_dx_load.num_a  = data_readRegA;
    w_dx_load.num_b  = w_i_type ? w_ext : data_readRegB;
    w_dx_load.regb   = data_readRegB;
    // Side-effecting controls only travel with a real instruction.
    w_dx_load.en     = en   & w_live;
    w_dx_load.mwen   = mwen & w_live;
    w_dx_load.lw     = lw   & w_live;
  end

  // Next D/X contents; reset is handled in the register process.
  always_comb begin
    w_dx_next = r_dx;
    if (flush) begin
      w_dx_next = w_dx_bubble;
    end else if (w_hold) begin
      w_dx_next = r_dx;
    end else if (w_hazard) begin
      w_dx_next = w_dx_bubble;
    end else begin
      w_dx_next = w_dx_load;
    end
  end

  // -------------------------------------------------------------------------
  // D/X register and bubble counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_dx <= w_dx_bubble;
    end else begin
      r_dx <= w_dx_next;
    end
  end

  // Counts only edges where a hazard bubble is actually inserted: not under
  // reset, flush or a backpressure hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (~flush & ~w_hold & w_hazard & (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out_valid   = r_dx.valid;
  assign out_nop     = r_dx.nop;
  assign out_pc      = r_dx.pc;
  assign out_target  = r_dx.target;
  assign out_opcode  = r_dx.opcode;
  assign out_rd      = r_dx.rd;
  assign out_shamt   = r_dx.shamt;
  assign out_aluop   = r_dx.aluop;
  assign num_a       = r_dx.num_a;
  assign num_b       = r_dx.num_b;
  assign out_regB    = r_dx.regb;
  assign out_en      = r_dx.en;
  assign out_mwen    = r_dx.mwen;
  assign out_lw      = r_dx.lw;
  assign stall_count = r_stall_count;

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised decode/issue stage for the 5-stage CPU pipeline, sitting between register-file read and execute. It forms the ALU operands, with a selectable sign- or zero-extended immediate for I-type instructions. Its D/X pipeline register supports downstream backpressure and flush. It also detects load-use hazards and inserts one bubble, with a saturating stall counter for performance monitoring.

## Interface
Parameters:
- DATA_W, 32, operand/register data width
- PC_W, 12, program counter and jump target width
- IMM_W, 17, immediate field width (must be ≤ DATA_W)
- SIGN_EXT, 1, 1 = sign-extend immediate, 0 = zero-extend
- CNT_W, 16, stall counter width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  decode inputs carry an instruction this cycle
- in_nop  in  1  instruction is a nop
- pc  in  PC_W  instruction PC
- opcode, rd, rs, rt, shamt, aluop  in  5 each  instruction fields
- imm  in  IMM_W  raw immediate
- target  in  PC_W  jump target
- en, mwen, lw  in  1 each  regfile write enable, memory write enable, load flag
- data_readRegA, data_readRegB  in  DATA_W  regfile read data for rs / rt
- flush  in  1  squash stage contents (taken branch/jump)
- ex_ready  in  1  execute accepts D/X contents this cycle
- stall  out  1  combinational; fetch/regfile-read must hold current inputs
- out_valid, out_nop  out  1 each  registered
- out_pc, out_target  out  PC_W  registered
- out_opcode, out_rd, out_shamt, out_aluop  out  5 each  registered
- num_a, num_b, out_regB  out  DATA_W  registered ALU operands; out_regB = raw rt data (sw data, branch compare)
- out_en, out_mwen, out_lw  out  1 each  registered
- stall_count  out  CNT_W  saturating count of hazard bubbles

## Operation
- I-type decode: sw=00111, ai=00101, bne=00010, blt=00110, plus the lw input; i_type = sw|ai|bne|blt|lw.
- Immediate: ext = imm extended to DATA_W. When SIGN_EXT=1, replicate imm[IMM_W-1]; otherwise zero-fill.
- Operands: num_a = data_readRegA; num_b = i_type ? ext : data_readRegB; out_regB = data_readRegB always.
- uses_rt = ~(ai | lw).
- hazard = in_valid & ~in_nop & out_valid & out_lw & (out_rd≠0) & ((rs==out_rd) | (uses_rt & rt==out_rd)).
- stall = hazard | (out_valid & ~ex_ready). stall is forced to 0 during reset and flush.
- Bubble: out_valid=0, out_nop=1. out_en, out_mwen and out_lw are 0. All data/field outputs are 0.
- Register update priority, per rising edge:
  1. reset → bubble, stall_count=0.
  2. flush → bubble.
  3. out_valid & ~ex_ready → hold all outputs.
  4. hazard → bubble; stall_count += 1, saturating at 2^CNT_W−1.
  5. otherwise load. out_valid=in_valid, all fields and operands captured; out_en, out_mwen and out_lw are gated by in_valid & ~in_nop.
- A bubble in the register never blocks: ex_ready is ignored when out_valid=0.

## Timing
- Latency: 1 cycle from accepted inputs to registered outputs.
- Reset: every output is 0, except out_nop=1. stall=0 during the reset cycle.
- Load-use: one hazard produces exactly one bubble cycle. On the next cycle the lw has left the register, hazard=0, and the held instruction loads.
- If hazard and ~ex_ready occur together, the hold takes priority. The hazard is re-evaluated every cycle and the counter increments only on the bubble-insert edge.
- flush in the same cycle as hazard or backpressure: flush wins. The register clears, stall=0, and the upstream instruction is discarded by the fetch-side flush.
- Reset asserted mid-stall clears state; the counter does not increment on that edge.
- rd=0 never triggers a hazard.

## Test plan
- Reset then idle → out_nop=1, out_valid=0, all other outputs 0, stall=0, stall_count=0.
- ai (00101) with imm=17'h1FFFF and regA=5, SIGN_EXT=1 → next cycle num_a=5, num_b=32'hFFFFFFFF. Same input with SIGN_EXT=0 → num_b=32'h0001FFFF.
- lw with rd=3, followed by an R-type with rs=3 → stall=1 for one cycle, one bubble, R-type issued the cycle after, stall_count=1. Same sequence with rd=0 → no stall.
- Valid instruction held with ex_ready=0 for 3 cycles → outputs stable and stall=1 for 3 cycles; the next instruction issues one cycle after ex_ready=1.
- flush asserted while a load-use hazard is pending → next cycle shows a bubble, stall=0, and stall_count is unchanged.
- 2^CNT_W+2 forced hazards with CNT_W=4 → stall_count saturates at 15.
